// File: rtl/rtc_pkg.sv
// Shared types and BCD helpers for the real-time clock slice.
package rtc_pkg;

   localparam int unsigned DIG_W = 4;
   localparam int unsigned BCD_W = 2 * DIG_W;

   typedef logic [DIG_W-1:0] bcd_digit_t;
   typedef logic [BCD_W-1:0] bcd_byte_t;

   typedef struct packed {
      bcd_byte_t hh;
      bcd_byte_t mm;
      bcd_byte_t ss;
   } rtc_time_t;

   localparam bcd_byte_t MAX_SS  = 8'h59;
   localparam bcd_byte_t MAX_MM  = 8'h59;
   localparam bcd_byte_t MAX_H24 = 8'h23;

   // Digit-wise BCD increment, wrapping to 00 after max.
   function automatic bcd_byte_t bcd_inc(input bcd_byte_t v, input bcd_byte_t max);
      bcd_byte_t r;
      if (v == max)
         r = '0;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic bcd_ok(input bcd_byte_t v, input bcd_byte_t max);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
   endfunction

   function automatic logic [7:0] bcd_to_bin(input bcd_byte_t v);
      return 8'(v[7:4]) * 8'd10 + 8'(v[3:0]);
   endfunction

   // Valid only for b <= 99.
   function automatic bcd_byte_t bin_to_bcd(input logic [7:0] b);
      return {4'(b / 8'd10), 4'(b % 8'd10)};
   endfunction

endpackage

// File: rtl/rtc_bcd_clock_if.sv
// Control/time bus of the BCD real-time clock.
interface rtc_bcd_clock_if;
   import rtc_pkg::*;

   logic      ena;
   logic      mode24;
   logic      set_stb;
   bcd_byte_t set_hh;
   bcd_byte_t set_mm;
   bcd_byte_t set_ss;
   logic      set_pm;
   logic      alm_stb;
   bcd_byte_t alm_hh;
   bcd_byte_t alm_mm;
   logic      alm_pm;
   logic      alm_en;
   logic      alm_ack;
   bcd_byte_t hh;
   bcd_byte_t mm;
   bcd_byte_t ss;
   logic      pm;
   logic      tick;
   logic      hour_pulse;
   logic      alm_irq;
   logic      set_err;

   modport master (
      output ena, mode24, set_stb, set_hh, set_mm, set_ss, set_pm,
             alm_stb, alm_hh, alm_mm, alm_pm, alm_en, alm_ack,
      input  hh, mm, ss, pm, tick, hour_pulse, alm_irq, set_err
   );

   modport slave (
      input  ena, mode24, set_stb, set_hh, set_mm, set_ss, set_pm,
             alm_stb, alm_hh, alm_mm, alm_pm, alm_en, alm_ack,
      output hh, mm, ss, pm, tick, hour_pulse, alm_irq, set_err
   );

endinterface

// File: rtl/bcd_hour_conv.sv
// 24h BCD hour -> display view, and port-format hour -> 24h BCD with range check.
module bcd_hour_conv
   import rtc_pkg::*;
(
   input  logic      mode24,
   input  bcd_byte_t h24_in,
   output bcd_byte_t hh_view,
   output logic      pm_view,
   input  bcd_byte_t hh_in,
   input  logic      pm_in,
   output bcd_byte_t h24_out,
   output logic      ok
);

   logic [7:0] hb;
   logic [7:0] h12;
   logic [7:0] ib;
   logic [7:0] base;
   logic       dig_ok;

   // Display direction: 00 shows as 12 AM, 13-23 as 01-11 PM.
   always_comb begin
      hb      = bcd_to_bin(h24_in);
      h12     = hb;
      pm_view = (hb >= 8'd12);
      if (hb == 8'd0)
         h12 = 8'd12;
      else if (hb > 8'd12)
         h12 = hb - 8'd12;
      hh_view = mode24 ? h24_in : bin_to_bcd(h12);
   end

   // Load direction: interpret hh_in in the currently selected format.
   always_comb begin
      ib      = bcd_to_bin(hh_in);
      base    = (ib == 8'd12) ? 8'd0 : ib;
      dig_ok  = (hh_in[7:4] <= 4'd9) && (hh_in[3:0] <= 4'd9);
      ok      = 1'b0;
      h24_out = hh_in;
      if (mode24) begin
         ok = dig_ok && (hh_in <= MAX_H24);
      end else begin
         ok      = dig_ok && (ib >= 8'd1) && (ib <= 8'd12);
         h24_out = bin_to_bcd(pm_in ? base + 8'd12 : base);
      end
   end

endmodule

// File: rtl/rtc_bcd_clock.sv
// BCD real-time clock: 1 s prescaler, hh:mm:ss counter, 12/24h view, time set, alarm.
module rtc_bcd_clock
   import rtc_pkg::*;
#(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned CNT_W    = 26
) (
   input  logic            clk,
   input  logic            reset,
   rtc_bcd_clock_if.slave  bus
);

   logic [CNT_W-1:0] cnt_q;
   rtc_time_t        time_q;
   rtc_time_t        next_time_c;
   rtc_time_t        set_time_c;
   bcd_byte_t        alm_hh_q;
   bcd_byte_t        alm_mm_q;
   logic             tick_q;
   logic             hour_pulse_q;
   logic             alm_irq_q;
   logic             set_err_q;

   bcd_byte_t        disp_hh;
   logic             disp_pm;
   bcd_byte_t        set_h24;
   logic             set_h_ok;
   bcd_byte_t        alm_h24;
   logic             alm_h_ok;
   bcd_byte_t        alm_view_hh_unused;
   logic             alm_view_pm_unused;

   logic             set_ok_c;
   logic             alm_ok_c;
   logic             set_load_c;
   logic             alm_load_c;
   logic             set_err_c;
   logic             wrap_c;
   logic             adv_c;
   logic             roll_c;
   logic             match_c;

   bcd_hour_conv u_main_conv (
      .mode24  (bus.mode24),
      .h24_in  (time_q.hh),
      .hh_view (disp_hh),
      .pm_view (disp_pm),
      .hh_in   (bus.set_hh),
      .pm_in   (bus.set_pm),
      .h24_out (set_h24),
      .ok      (set_h_ok)
   );

   bcd_hour_conv u_alm_conv (
      .mode24  (bus.mode24),
      .h24_in  (alm_hh_q),
      .hh_view (alm_view_hh_unused),
      .pm_view (alm_view_pm_unused),
      .hh_in   (bus.alm_hh),
      .pm_in   (bus.alm_pm),
      .h24_out (alm_h24),
      .ok      (alm_h_ok)
   );

   // Port validation and load qualification.
   always_comb begin
      set_ok_c   = set_h_ok && bcd_ok(bus.set_mm, MAX_MM) && bcd_ok(bus.set_ss, MAX_SS);
      alm_ok_c   = alm_h_ok && bcd_ok(bus.alm_mm, MAX_MM);
      set_load_c = bus.set_stb && set_ok_c;
      alm_load_c = bus.alm_stb && alm_ok_c;
      set_err_c  = (bus.set_stb && !set_ok_c) || (bus.alm_stb && !alm_ok_c);
      set_time_c = '{hh: set_h24, mm: bus.set_mm, ss: bus.set_ss};
   end

   // One-second advance with carries; a valid set pre-empts it.
   always_comb begin
      wrap_c         = bus.ena && (cnt_q == CNT_W'(TICK_DIV - 1));
      adv_c          = wrap_c && !set_load_c;
      roll_c         = (time_q.ss == MAX_SS) && (time_q.mm == MAX_MM);
      next_time_c    = time_q;
      next_time_c.ss = bcd_inc(time_q.ss, MAX_SS);
      if (time_q.ss == MAX_SS) begin
         next_time_c.mm = bcd_inc(time_q.mm, MAX_MM);
         if (time_q.mm == MAX_MM)
            next_time_c.hh = bcd_inc(time_q.hh, MAX_H24);
      end
      match_c = bus.alm_en && (next_time_c.hh == alm_hh_q) &&
                (next_time_c.mm == alm_mm_q) && (next_time_c.ss == 8'h00);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         time_q       <= '0;
         alm_hh_q     <= '0;
         alm_mm_q     <= '0;
         tick_q       <= 1'b0;
         hour_pulse_q <= 1'b0;
         alm_irq_q    <= 1'b0;
         set_err_q    <= 1'b0;
      end else begin
         tick_q       <= 1'b0;
         hour_pulse_q <= 1'b0;
         set_err_q    <= set_err_c;
         if (set_load_c) begin
            time_q <= set_time_c;
            cnt_q  <= '0;
         end else if (bus.ena) begin
            if (wrap_c) begin
               cnt_q        <= '0;
               time_q       <= next_time_c;
               tick_q       <= 1'b1;
               hour_pulse_q <= roll_c;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (alm_load_c) begin
            alm_hh_q <= alm_h24;
            alm_mm_q <= bus.alm_mm;
         end
         if (adv_c && match_c)
            alm_irq_q <= 1'b1;
         else if (bus.alm_ack)
            alm_irq_q <= 1'b0;
      end
   end

   assign bus.hh         = disp_hh;
   assign bus.pm         = disp_pm;
   assign bus.mm         = time_q.mm;
   assign bus.ss         = time_q.ss;
   assign bus.tick       = tick_q;
   assign bus.hour_pulse = hour_pulse_q;
   assign bus.alm_irq    = alm_irq_q;
   assign bus.set_err    = set_err_q;

endmodule
